// File: rtl/frame_data_writer_if.sv
// Frame data writer bus bundle.
// Groups the configuration word handshake (source -> writer) and the frame
// data / row select / strobe outputs (writer -> row registers).
//   slave  : the frame_data_writer side
//   master : the word source / observer side
interface frame_data_writer_if #(
    parameter int FrameBitsPerRow = 32,
    parameter int RowSelectWidth  = 5,
    parameter int FrameAddrWidth  = 8
);
    logic [FrameBitsPerRow-1:0] WordData_I;
    logic                       WordValid_I;
    logic                       WordReady_O;
    logic [FrameBitsPerRow-1:0] FrameData_O;
    logic [RowSelectWidth-1:0]  RowSelect_O;
    logic [FrameAddrWidth-1:0]  FrameAddr_O;
    logic                       FrameStrobe_O;
    logic                       HeaderError_O;
    logic                       Busy_O;

    modport slave (
        input  WordData_I, WordValid_I,
        output WordReady_O, FrameData_O, RowSelect_O, FrameAddr_O,
               FrameStrobe_O, HeaderError_O, Busy_O
    );

    modport master (
        output WordData_I, WordValid_I,
        input  WordReady_O, FrameData_O, RowSelect_O, FrameAddr_O,
               FrameStrobe_O, HeaderError_O, Busy_O
    );
endinterface

// File: rtl/frame_data_writer.sv
// Frame data writer.
// Takes a header word followed by one data word per row, places each data
// word on the shared frame data bus with the target row selected, then emits
// a single frame strobe carrying the frame address.
// Ports:
//   CLK   : clock, rising edge
//   RESET : synchronous active-high reset
//   bus   : frame_data_writer_if.slave (word handshake in, frame bus out)
//
// state  | meaning
// IDLE   | waiting for a header word
// DATA   | one row written per accepted data word
// SETTLE | last row still selected, input stalled
// STROBE | frame strobe with stored address
module frame_data_writer #(
    parameter int FrameBitsPerRow = 32,
    parameter int RowSelectWidth  = 5,
    parameter int NumberOfRows    = 16,
    parameter int FrameAddrWidth  = 8,
    parameter logic [RowSelectWidth-1:0] IdleRowSelect = '1
) (
    input logic                CLK,
    input logic                RESET,
    frame_data_writer_if.slave bus
);
    localparam int SumW = RowSelectWidth + 1;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_SETTLE, S_STROBE} state_t;

    state_t                     state_q, state_d;
    logic [RowSelectWidth-1:0]  row_q, row_d;
    logic [RowSelectWidth-1:0]  remaining_q, remaining_d;
    logic [FrameAddrWidth-1:0]  addr_store_q, addr_store_d;
    logic [FrameBitsPerRow-1:0] frame_data_q, frame_data_d;
    logic [RowSelectWidth-1:0]  row_sel_q, row_sel_d;
    logic [FrameAddrWidth-1:0]  frame_addr_q, frame_addr_d;
    logic                       strobe_q, strobe_d;
    logic                       hdr_err_q, hdr_err_d;

    logic                       word_ready;
    logic                       busy;
    logic                       accept;
    logic [RowSelectWidth-1:0]  hdr_start;
    logic [RowSelectWidth-1:0]  hdr_count_m1;
    logic [FrameAddrWidth-1:0]  hdr_addr;
    logic [SumW-1:0]            hdr_last_row;
    logic                       hdr_ok;

    assign accept       = bus.WordValid_I & word_ready;
    assign hdr_start    = bus.WordData_I[RowSelectWidth-1:0];
    assign hdr_count_m1 = bus.WordData_I[8 +: RowSelectWidth];
    assign hdr_addr     = bus.WordData_I[16 +: FrameAddrWidth];
    // One extra bit so start_row + count_m1 cannot wrap before the range check.
    assign hdr_last_row = {1'b0, hdr_start} + {1'b0, hdr_count_m1};
    assign hdr_ok       = bus.WordData_I[31] && (hdr_last_row < SumW'(NumberOfRows));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            row_q        <= '0;
            remaining_q  <= '0;
            addr_store_q <= '0;
            frame_data_q <= '0;
            row_sel_q    <= IdleRowSelect;
            frame_addr_q <= '0;
            strobe_q     <= 1'b0;
            hdr_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            remaining_q  <= remaining_d;
            addr_store_q <= addr_store_d;
            frame_data_q <= frame_data_d;
            row_sel_q    <= row_sel_d;
            frame_addr_q <= frame_addr_d;
            strobe_q     <= strobe_d;
            hdr_err_q    <= hdr_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        remaining_d  = remaining_q;
        addr_store_d = addr_store_q;
        frame_data_d = frame_data_q;
        row_sel_d    = row_sel_q;
        frame_addr_d = frame_addr_q;
        strobe_d     = 1'b0;
        hdr_err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (hdr_ok) begin
                        row_d        = hdr_start;
                        remaining_d  = hdr_count_m1;
                        addr_store_d = hdr_addr;
                        state_d      = S_DATA;
                    end else begin
                        hdr_err_d = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    frame_data_d = bus.WordData_I;
                    row_sel_d    = row_q;
                    // After the last word these wrap harmlessly; both are reloaded by the next header.
                    row_d        = row_q + RowSelectWidth'(1);
                    remaining_d  = remaining_q - RowSelectWidth'(1);
                    if (remaining_q == '0) begin
                        state_d = S_SETTLE;
                    end
                end else begin
                    // Stall: deselect so no row latches the held data twice.
                    row_sel_d = IdleRowSelect;
                end
            end
            S_SETTLE: begin
                row_sel_d    = IdleRowSelect;
                frame_addr_d = addr_store_q;
                strobe_d     = 1'b1;
                state_d      = S_STROBE;
            end
            S_STROBE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        word_ready = (state_q == S_IDLE) || (state_q == S_DATA);
        busy       = (state_q != S_IDLE);
    end

    assign bus.WordReady_O   = word_ready;
    assign bus.Busy_O        = busy;
    assign bus.FrameData_O   = frame_data_q;
    assign bus.RowSelect_O   = row_sel_q;
    assign bus.FrameAddr_O   = frame_addr_q;
    assign bus.FrameStrobe_O = strobe_q;
    assign bus.HeaderError_O = hdr_err_q;
endmodule

// File: tb/tb_frame_data_writer.sv
module tb_frame_data_writer;
    localparam logic [4:0] IDLE_SEL = 5'h1F;

    typedef struct {
        logic [31:0] word;
        logic        exp_err;
    } hdr_vec_t;

    typedef struct {
        logic [4:0]  row;
        logic [31:0] data;
    } wr_t;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    frame_data_writer_if bus ();

    frame_data_writer dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state for the random phase: expected bus writes,
    // strobe addresses and header errors, in order.
    wr_t        exp_wr[$];
    logic [7:0] exp_strobe[$];
    int         exp_err_cnt = 0;
    bit         mon_en = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    task automatic step(input logic v, input logic [31:0] d);
        bus.WordValid_I = v;
        bus.WordData_I  = d;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic check_reset_vals(string tag);
        chk({tag, "_framedata"}, bus.FrameData_O, 32'h0);
        chk({tag, "_rowsel"}, 32'(bus.RowSelect_O), 32'(IDLE_SEL));
        chk({tag, "_frameaddr"}, 32'(bus.FrameAddr_O), 32'h0);
        chk({tag, "_strobe"}, 32'(bus.FrameStrobe_O), 32'h0);
        chk({tag, "_hdrerr"}, 32'(bus.HeaderError_O), 32'h0);
        chk({tag, "_busy"}, 32'(bus.Busy_O), 32'h0);
        chk({tag, "_ready"}, 32'(bus.WordReady_O), 32'h1);
    endtask

    // Single-row frame with exact cycle-by-cycle expectations.
    task automatic single_frame(input logic [4:0] start, input logic [7:0] addr,
                                input logic [31:0] data);
        logic [31:0] hdr;
        hdr = 32'h8000_0000 | (32'(addr) << 16) | 32'(start);
        step(1'b1, hdr);
        chk("sf_busy_after_hdr", 32'(bus.Busy_O), 32'h1);
        chk("sf_ready_after_hdr", 32'(bus.WordReady_O), 32'h1);
        step(1'b1, data);
        chk("sf_rowsel", 32'(bus.RowSelect_O), 32'(start));
        chk("sf_framedata", bus.FrameData_O, data);
        chk("sf_ready_settle", 32'(bus.WordReady_O), 32'h0);
        chk("sf_strobe_early", 32'(bus.FrameStrobe_O), 32'h0);
        step(1'b0, 32'h0);
        chk("sf_strobe", 32'(bus.FrameStrobe_O), 32'h1);
        chk("sf_frameaddr", 32'(bus.FrameAddr_O), 32'(addr));
        chk("sf_rowsel_idle", 32'(bus.RowSelect_O), 32'(IDLE_SEL));
        chk("sf_ready_strobe", 32'(bus.WordReady_O), 32'h0);
        step(1'b0, 32'h0);
        chk("sf_ready_back", 32'(bus.WordReady_O), 32'h1);
        chk("sf_busy_back", 32'(bus.Busy_O), 32'h0);
        chk("sf_strobe_once", 32'(bus.FrameStrobe_O), 32'h0);
    endtask

    // 16-row frame, optional 3-cycle stall after word gap_after.
    task automatic frame16(input int gap_after);
        int low;
        int strobes;
        step(1'b1, 32'h8012_0F00);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 32'(i));
            chk("f16_rowsel", 32'(bus.RowSelect_O), 32'(i));
            chk("f16_data", bus.FrameData_O, 32'(i));
            if (i == gap_after) begin
                for (int g = 0; g < 3; g++) begin
                    step(1'b0, 32'hFFFF_FFFF);
                    chk("f16_gap_rowsel", 32'(bus.RowSelect_O), 32'(IDLE_SEL));
                    chk("f16_gap_hold", bus.FrameData_O, 32'(i));
                    chk("f16_gap_ready", 32'(bus.WordReady_O), 32'h1);
                end
            end
        end
        low     = bus.WordReady_O ? 0 : 1;
        strobes = 0;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 32'h0);
            if (!bus.WordReady_O) low++;
            if (bus.FrameStrobe_O) begin
                strobes++;
                chk("f16_frameaddr", 32'(bus.FrameAddr_O), 32'h12);
            end
        end
        chk("f16_ready_low_cycles", 32'(low), 32'd2);
        chk("f16_strobe_count", 32'(strobes), 32'd1);
    endtask

    task automatic send(input logic [31:0] w);
        int  t;
        bit  ok;
        t  = 0;
        ok = 1'b0;
        bus.WordValid_I = 1'b1;
        bus.WordData_I  = w;
        do begin
            ok = bus.WordReady_O;
            @(posedge CLK);
            @(negedge CLK);
            t++;
        end while (!ok && t < 20);
        if (!ok) chk("ready_timeout", 32'(ok), 32'h1);
        bus.WordValid_I = 1'b0;
    endtask

    // Transaction-level monitor for the random phase.
    always @(negedge CLK) begin : monitor
        wr_t w;
        if (mon_en) begin
            if (bus.RowSelect_O !== IDLE_SEL) begin
                if (exp_wr.size() == 0) begin
                    chk("unexpected_write", 32'(bus.RowSelect_O), 32'(IDLE_SEL));
                end else begin
                    w = exp_wr.pop_front();
                    chk("rnd_row", 32'(bus.RowSelect_O), 32'(w.row));
                    chk("rnd_data", bus.FrameData_O, w.data);
                end
            end
            if (bus.FrameStrobe_O) begin
                if (exp_strobe.size() == 0)
                    chk("unexpected_strobe", 32'(bus.FrameStrobe_O), 32'h0);
                else
                    chk("rnd_frameaddr", 32'(bus.FrameAddr_O), 32'(exp_strobe.pop_front()));
            end
            if (bus.HeaderError_O) begin
                if (exp_err_cnt == 0)
                    chk("unexpected_hdr_err", 32'(bus.HeaderError_O), 32'h0);
                else
                    exp_err_cnt--;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        hdr_vec_t    hv[8];
        int          strobes;
        int          cnt;
        logic [31:0] hdr;
        logic [31:0] dq[$];
        int          s, c;
        bit          legal;

        hv[0] = '{32'h0005_0002, 1'b1};
        hv[1] = '{32'h8000_030E, 1'b1};
        hv[2] = '{32'h8000_010E, 1'b0};
        hv[3] = '{32'h8000_000F, 1'b0};
        hv[4] = '{32'h8000_0010, 1'b1};
        hv[5] = '{32'h8000_1F00, 1'b1};
        hv[6] = '{32'h7FFF_FFFF, 1'b1};
        hv[7] = '{32'h8000_0F00, 1'b0};

        RESET           = 1'b1;
        bus.WordValid_I = 1'b0;
        bus.WordData_I  = '0;
        step(1'b0, 32'h0);
        step(1'b0, 32'h0);
        RESET = 1'b0;
        step(1'b0, 32'h0);
        check_reset_vals("reset");

        single_frame(5'd2, 8'h05, 32'hDEAD_BEEF);
        frame16(-1);
        frame16(4);

        for (int v = 0; v < 8; v++) begin
            step(1'b1, hv[v].word);
            chk("hdr_err", 32'(bus.HeaderError_O), 32'(hv[v].exp_err));
            chk("hdr_busy", 32'(bus.Busy_O), 32'(!hv[v].exp_err));
            chk("hdr_rowsel", 32'(bus.RowSelect_O), 32'(IDLE_SEL));
            chk("hdr_strobe", 32'(bus.FrameStrobe_O), 32'h0);
            if (!hv[v].exp_err) begin
                cnt = int'(hv[v].word[12:8]);
                for (int j = 0; j <= cnt; j++) step(1'b1, 32'(j) + 32'h100);
                step(1'b0, 32'h0);
                step(1'b0, 32'h0);
            end
            step(1'b0, 32'h0);
            chk("hdr_err_cleared", 32'(bus.HeaderError_O), 32'h0);
            chk("hdr_idle", 32'(bus.Busy_O), 32'h0);
        end

        // Reset in the middle of an 8-row frame.
        step(1'b1, 32'h8044_0703);
        for (int j = 0; j < 5; j++) step(1'b1, 32'hA0 + 32'(j));
        RESET = 1'b1;
        step(1'b1, 32'h55);
        check_reset_vals("midreset");
        RESET   = 1'b0;
        strobes = 0;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 32'h0);
            if (bus.FrameStrobe_O) strobes++;
        end
        chk("midreset_no_strobe", 32'(strobes), 32'd0);
        single_frame(5'd7, 8'h3C, 32'h1234_5678);

        // Randomized frames against the reference model.
        mon_en = 1'b1;
        for (int f = 0; f < 60; f++) begin
            if ($urandom_range(0, 4) == 0) begin
                hdr = $urandom;
            end else begin
                s   = $urandom_range(0, 15);
                c   = $urandom_range(0, 15 - s);
                hdr = {1'b1, 7'($urandom), 8'($urandom), 3'($urandom), 5'(c),
                       3'($urandom), 5'(s)};
            end
            s     = int'(hdr[4:0]);
            c     = int'(hdr[12:8]);
            legal = hdr[31] && (s + c < 16);
            if (legal) begin
                dq.delete();
                for (int i = 0; i <= c; i++) begin
                    dq.push_back($urandom);
                    exp_wr.push_back('{5'(s + i), dq[i]});
                end
                exp_strobe.push_back(hdr[23:16]);
                send(hdr);
                for (int i = 0; i <= c; i++) begin
                    if ($urandom_range(0, 3) == 0)
                        repeat ($urandom_range(1, 3)) step(1'b0, $urandom);
                    send(dq[i]);
                end
            end else begin
                exp_err_cnt++;
                send(hdr);
            end
        end
        repeat (6) step(1'b0, 32'h0);
        mon_en = 1'b0;
        chk("leftover_writes", 32'(exp_wr.size()), 32'd0);
        chk("leftover_strobes", 32'(exp_strobe.size()), 32'd0);
        chk("leftover_hdr_errs", 32'(exp_err_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
